// File: rtl/mem_arbiter.sv
// Shares the single byte-addressed data RAM between instruction fetch and load/store.
// Round-robin grant, legality checks, start/done handshake with timeout, load extension.
module mem_arbiter #(
  parameter int MEM_SIZE = 4096,
  parameter int TIMEOUT  = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_adr,
  output logic        if_ack,
  output logic [31:0] if_data,
  output logic        if_err,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_adr,
  input  logic [31:0] dm_wdata,
  input  logic [2:0]  dm_siz,
  output logic        dm_ack,
  output logic [31:0] dm_rdata,
  output logic        dm_err,
  output logic        ram_start,
  output logic [31:0] ram_adr,
  output logic        ram_load,
  output logic [31:0] ram_in,
  output logic [2:0]  ram_siz,
  input  logic [31:0] ram_out,
  input  logic        ram_done,
  output logic        busy
);

  localparam int            CW        = $clog2(TIMEOUT + 1);
  localparam logic [32:0]   MEM_LIMIT = 33'(MEM_SIZE);
  localparam logic [CW-1:0] CNT_LAST  = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};

  localparam logic [2:0] SIZ_BYTE = 3'd0;
  localparam logic [2:0] SIZ_HALF = 3'd1;
  localparam logic [2:0] SIZ_WORD = 3'd2;
  localparam logic [2:0] SIZ_BU   = 3'd4;
  localparam logic [2:0] SIZ_HU   = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_ACK   = 2'd3
  } state_t;

  state_t        state_r, state_s;
  logic          last_grant_r;   // 1 = data port was granted last
  logic          grant_dm_r;
  logic [31:0]   adr_r;
  logic          we_r;
  logic [31:0]   wdata_r;
  logic [2:0]    siz_r;
  logic [2:0]    ram_siz_r;
  logic [CW-1:0] cnt_r;
  logic          ram_start_r;
  logic          busy_r;
  logic          if_ack_r, if_err_r, dm_ack_r, dm_err_r;
  logic [31:0]   if_data_r, dm_rdata_r;

  logic          any_req_s;
  logic          sel_dm_s;
  logic [31:0]   cand_adr_s;
  logic          cand_we_s;
  logic [31:0]   cand_wdata_s;
  logic [2:0]    cand_siz_s;
  logic          cand_bad_s;
  logic          done_ok_s;
  logic          tmo_s;

  function automatic logic access_bad(input logic [31:0] adr, input logic we,
                                      input logic [2:0] siz);
    logic [2:0] nb;
    logic       illegal;
    logic       misalign;
    logic       range_err;
    nb       = 3'd0;
    illegal  = 1'b0;
    misalign = 1'b0;
    case (siz)
      SIZ_BYTE: nb = 3'd1;
      SIZ_HALF: begin nb = 3'd2; misalign = adr[0]; end
      SIZ_WORD: begin nb = 3'd4; misalign = (adr[1:0] != 2'b00); end
      SIZ_BU:   begin nb = 3'd1; illegal = we; end
      SIZ_HU:   begin nb = 3'd2; misalign = adr[0]; illegal = we; end
      default:  illegal = 1'b1;
    endcase
    range_err  = ({1'b0, adr} + {30'd0, nb}) > MEM_LIMIT;
    access_bad = illegal | misalign | range_err;
  endfunction

  // The RAM only knows signed-agnostic sizes 0..2.
  function automatic logic [2:0] ram_siz_map(input logic [2:0] siz);
    case (siz)
      SIZ_BU:  ram_siz_map = SIZ_BYTE;
      SIZ_HU:  ram_siz_map = SIZ_HALF;
      default: ram_siz_map = siz;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [2:0] siz, input logic [31:0] raw);
    case (siz)
      SIZ_BYTE: load_ext = {{24{raw[7]}}, raw[7:0]};
      SIZ_HALF: load_ext = {{16{raw[15]}}, raw[15:0]};
      SIZ_BU:   load_ext = {24'd0, raw[7:0]};
      SIZ_HU:   load_ext = {16'd0, raw[15:0]};
      default:  load_ext = raw;
    endcase
  endfunction

  // Pick the winning requester and check the access it presents.
  always_comb begin
    any_req_s    = if_req | dm_req;
    sel_dm_s     = 1'b0;
    cand_adr_s   = 32'd0;
    cand_we_s    = 1'b0;
    cand_wdata_s = 32'd0;
    cand_siz_s   = SIZ_WORD;
    if (if_req && dm_req) begin
      sel_dm_s = ~last_grant_r;
    end else if (dm_req) begin
      sel_dm_s = 1'b1;
    end else begin
      sel_dm_s = 1'b0;
    end
    if (sel_dm_s) begin
      cand_adr_s   = dm_adr;
      cand_we_s    = dm_we;
      cand_wdata_s = dm_wdata;
      cand_siz_s   = dm_siz;
    end else begin
      cand_adr_s   = if_adr;
      cand_we_s    = 1'b0;
      cand_wdata_s = 32'd0;
      cand_siz_s   = SIZ_WORD;
    end
    cand_bad_s = access_bad(cand_adr_s, cand_we_s, cand_siz_s);
  end

  // Next-state logic; done is ignored on the first WAIT cycle.
  always_comb begin
    state_s   = state_r;
    done_ok_s = (cnt_r != CNT_ZERO) && ram_done;
    tmo_s     = (cnt_r == CNT_LAST);
    case (state_r)
      S_IDLE: begin
        if (any_req_s) begin
          state_s = cand_bad_s ? S_ACK : S_START;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_START: state_s = S_WAIT;
      S_WAIT: begin
        if (done_ok_s || tmo_s) begin
          state_s = S_ACK;
        end else begin
          state_s = S_WAIT;
        end
      end
      S_ACK:   state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // State, request latch, RAM strobe and registered completion outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= S_IDLE;
      last_grant_r <= 1'b0;
      grant_dm_r   <= 1'b0;
      adr_r        <= 32'd0;
      we_r         <= 1'b0;
      wdata_r      <= 32'd0;
      siz_r        <= 3'd0;
      ram_siz_r    <= 3'd0;
      cnt_r        <= CNT_ZERO;
      ram_start_r  <= 1'b0;
      busy_r       <= 1'b0;
      if_ack_r     <= 1'b0;
      if_err_r     <= 1'b0;
      if_data_r    <= 32'd0;
      dm_ack_r     <= 1'b0;
      dm_err_r     <= 1'b0;
      dm_rdata_r   <= 32'd0;
    end else begin
      state_r     <= state_s;
      busy_r      <= (state_s != S_IDLE);
      ram_start_r <= (state_s == S_START);
      if_ack_r    <= 1'b0;
      if_err_r    <= 1'b0;
      if_data_r   <= 32'd0;
      dm_ack_r    <= 1'b0;
      dm_err_r    <= 1'b0;
      dm_rdata_r  <= 32'd0;
      case (state_r)
        S_IDLE: begin
          if (any_req_s) begin
            grant_dm_r   <= sel_dm_s;
            last_grant_r <= sel_dm_s;
            adr_r        <= cand_adr_s;
            we_r         <= cand_we_s;
            wdata_r      <= cand_wdata_s;
            siz_r        <= cand_siz_s;
            ram_siz_r    <= ram_siz_map(cand_siz_s);
            if (cand_bad_s) begin
              if_ack_r <= ~sel_dm_s;
              if_err_r <= ~sel_dm_s;
              dm_ack_r <= sel_dm_s;
              dm_err_r <= sel_dm_s;
            end
          end
        end
        S_START: cnt_r <= CNT_ZERO;
        S_WAIT: begin
          if (done_ok_s) begin
            if_ack_r   <= ~grant_dm_r;
            dm_ack_r   <= grant_dm_r;
            if_data_r  <= grant_dm_r ? 32'd0 : ram_out;
            dm_rdata_r <= (grant_dm_r && !we_r) ? load_ext(siz_r, ram_out) : 32'd0;
          end else if (tmo_s) begin
            if_ack_r <= ~grant_dm_r;
            if_err_r <= ~grant_dm_r;
            dm_ack_r <= grant_dm_r;
            dm_err_r <= grant_dm_r;
          end else begin
            cnt_r <= cnt_r + 1'b1;
          end
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  assign if_ack    = if_ack_r;
  assign if_data   = if_data_r;
  assign if_err    = if_err_r;
  assign dm_ack    = dm_ack_r;
  assign dm_rdata  = dm_rdata_r;
  assign dm_err    = dm_err_r;
  assign ram_start = ram_start_r;
  assign ram_adr   = adr_r;
  assign ram_load  = we_r;
  assign ram_in    = wdata_r;
  assign ram_siz   = ram_siz_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: RAM responder model, directed table, hand sequences for
// arbitration/timeout/reset, and random two-port traffic against a byte-array reference.
module tb_mem_arbiter;
  localparam int MEM_SIZE = 4096;
  localparam int TIMEOUT  = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_ack, if_err;
  logic [31:0] if_adr, if_data;
  logic        dm_req, dm_we, dm_ack, dm_err;
  logic [31:0] dm_adr, dm_wdata, dm_rdata;
  logic [2:0]  dm_siz;
  logic        ram_start, ram_load;
  logic [31:0] ram_adr, ram_in;
  logic [31:0] ram_out = 32'd0;
  logic [2:0]  ram_siz;
  logic        ram_done = 1'b0;
  logic        busy;

  always #5 clk = ~clk;

  mem_arbiter #(.MEM_SIZE(MEM_SIZE), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_adr(if_adr), .if_ack(if_ack), .if_data(if_data), .if_err(if_err),
    .dm_req(dm_req), .dm_we(dm_we), .dm_adr(dm_adr), .dm_wdata(dm_wdata), .dm_siz(dm_siz),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata), .dm_err(dm_err),
    .ram_start(ram_start), .ram_adr(ram_adr), .ram_load(ram_load), .ram_in(ram_in),
    .ram_siz(ram_siz), .ram_out(ram_out), .ram_done(ram_done), .busy(busy)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0]  ram_mem [0:MEM_SIZE-1];
  logic [7:0]  ref_mem [0:MEM_SIZE-1];
  int          ram_starts = 0;
  int          ram_cnt = 0;
  int          last_delay = 1;
  int          ram_nb;
  logic [31:0] ram_w;
  bit          hang = 1'b0;
  bit          mon_on = 1'b0;
  time         dm_rise = 0, if_rise = 0, prev_ack_t = 0;
  bit          prev_dm = 1'b0, prev_valid = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // RAM responder: executes on the start strobe, raises done after a random delay.
  always @(negedge clk) begin
    if (ram_start) begin
      ram_starts++;
      case (ram_siz)
        3'd0: ram_nb = 1;
        3'd1: ram_nb = 2;
        3'd2: ram_nb = 4;
        default: ram_nb = 0;
      endcase
      chk("ram_cmd", {31'd0, (ram_nb != 0) && (longint'(ram_adr) + ram_nb <= MEM_SIZE)}, 32'd1);
      if (ram_nb != 0 && longint'(ram_adr) + ram_nb <= MEM_SIZE) begin
        if (ram_load) begin
          for (int i = 0; i < ram_nb; i++) ram_mem[ram_adr + i] = ram_in[8*i +: 8];
        end else begin
          ram_w = $urandom;  // junk above the accessed bytes
          for (int i = 0; i < ram_nb; i++) ram_w[8*i +: 8] = ram_mem[ram_adr + i];
          ram_out = ram_w;
        end
      end
      ram_done   = 1'b0;
      last_delay = $urandom_range(1, 4);
      ram_cnt    = last_delay;
    end else if (ram_cnt > 0) begin
      ram_cnt--;
      if (ram_cnt == 0 && !hang) ram_done = 1'b1;
    end
  end

  // Protocol monitor: ack exclusivity, quiet outputs outside ack, bounded starvation.
  always @(negedge clk) begin
    if (mon_on) begin
      chk("ack_overlap", {31'd0, dm_ack & if_ack}, 32'd0);
      if (!dm_ack) chk("dm_quiet", {dm_rdata[30:0], dm_err}, 32'd0);
      if (!if_ack) chk("if_quiet", {if_data[30:0], if_err}, 32'd0);
      if (dm_ack || if_ack) begin
        chk("fairness", {31'd0, prev_valid && (prev_dm == dm_ack) &&
            (dm_ack ? (if_req && if_rise < prev_ack_t) : (dm_req && dm_rise < prev_ack_t))}, 32'd0);
        prev_dm    = dm_ack;
        prev_ack_t = $time;
        prev_valid = 1'b1;
      end
    end
  end

  // Reference: byte-array semantics of the load/store/fetch rules.
  task automatic ref_exec(input logic we, input logic [31:0] adr, input logic [31:0] wd,
                          input logic [2:0] siz, output logic [31:0] rd, output logic er);
    int nb;
    longint v;
    case (siz)
      3'd0, 3'd4: nb = 1;
      3'd1, 3'd5: nb = 2;
      3'd2:       nb = 4;
      default:    nb = 0;
    endcase
    er = (nb == 0) || (we && siz >= 3'd4);
    if (!er) er = ((adr % nb) != 0) || (longint'(adr) + nb > MEM_SIZE);
    rd = 32'd0;
    if (!er) begin
      v = 0;
      for (int i = nb - 1; i >= 0; i--) v = v * 256 + ref_mem[adr + i];
      if (we) begin
        for (int i = 0; i < nb; i++) ref_mem[adr + i] = 8'((wd >> (8 * i)) & 32'hFF);
      end else begin
        if (siz == 3'd0 && v >= 128) v -= 256;
        if (siz == 3'd1 && v >= 32768) v -= 65536;
        rd = 32'(v);
      end
    end
  endtask

  task automatic xact(input bit is_dm, input logic we, input logic [31:0] adr,
                      input logic [31:0] wd, input logic [2:0] siz,
                      output logic [31:0] rd, output logic er, output int lat, output int nst,
                      output logic [31:0] exp_rd, output logic exp_er);
    int s0;
    bit got;
    @(posedge clk); #1;
    if (is_dm) begin
      dm_we = we; dm_adr = adr; dm_wdata = wd; dm_siz = siz; dm_req = 1'b1; dm_rise = $time;
    end else begin
      if_adr = adr; if_req = 1'b1; if_rise = $time;
    end
    s0 = ram_starts; got = 1'b0; lat = 0; rd = 32'd0; er = 1'b0;
    for (int c = 1; c <= 100 && !got; c++) begin
      @(negedge clk);
      if (is_dm ? dm_ack : if_ack) begin
        got = 1'b1; lat = c;
        rd = is_dm ? dm_rdata : if_data;
        er = is_dm ? dm_err : if_err;
      end
    end
    nst = ram_starts - s0;
    ref_exec(is_dm ? we : 1'b0, adr, wd, is_dm ? siz : 3'd2, exp_rd, exp_er);
    if (is_dm) chk("dm_ack_seen", {31'd0, got}, 32'd1);
    else       chk("if_ack_seen", {31'd0, got}, 32'd1);
    @(posedge clk); #1;
    if (is_dm) dm_req = 1'b0; else if_req = 1'b0;
  endtask

  function automatic logic [31:0] rnd_adr();
    int m;
    m = $urandom_range(0, 9);
    if (m < 6)      return 32'($urandom_range(0, 63));
    else if (m < 9) return 32'(MEM_SIZE - 8 + $urandom_range(0, 7));
    else            return $urandom;
  endfunction

  function automatic logic [2:0] rnd_siz();
    if ($urandom_range(0, 9) == 0) begin
      case ($urandom_range(0, 2))
        0:       return 3'd3;
        1:       return 3'd6;
        default: return 3'd7;
      endcase
    end
    case ($urandom_range(0, 5))
      0:       return 3'd0;
      1:       return 3'd1;
      2, 3:    return 3'd2;
      4:       return 3'd4;
      default: return 3'd5;
    endcase
  endfunction

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] wd;
    logic [2:0]  siz;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t        tv [18];
  logic [31:0] rd, exp_rd;
  logic        er, exp_er;
  int          lat, nst, nacks;
  logic [3:0]  order;

  initial begin
    tv[0]  = '{1'b1, 32'h010, 32'hDEADBEEF, 3'd2, 32'h00000000, 1'b0};
    tv[1]  = '{1'b0, 32'h010, 32'h00000000, 3'd2, 32'hDEADBEEF, 1'b0};
    tv[2]  = '{1'b1, 32'h020, 32'hAAAAAA80, 3'd0, 32'h00000000, 1'b0};
    tv[3]  = '{1'b0, 32'h020, 32'h00000000, 3'd0, 32'hFFFFFF80, 1'b0};
    tv[4]  = '{1'b0, 32'h020, 32'h00000000, 3'd4, 32'h00000080, 1'b0};
    tv[5]  = '{1'b1, 32'h022, 32'h55558001, 3'd1, 32'h00000000, 1'b0};
    tv[6]  = '{1'b0, 32'h022, 32'h00000000, 3'd1, 32'hFFFF8001, 1'b0};
    tv[7]  = '{1'b0, 32'h022, 32'h00000000, 3'd5, 32'h00008001, 1'b0};
    tv[8]  = '{1'b0, 32'h021, 32'h00000000, 3'd1, 32'h00000000, 1'b1};
    tv[9]  = '{1'b1, 32'h030, 32'h000000FF, 3'd4, 32'h00000000, 1'b1};
    tv[10] = '{1'b0, 32'h012, 32'h00000000, 3'd2, 32'h00000000, 1'b1};
    tv[11] = '{1'b0, 32'h1000, 32'h00000000, 3'd0, 32'h00000000, 1'b1};
    tv[12] = '{1'b0, 32'hFFF, 32'h00000000, 3'd4, 32'h00000000, 1'b0};
    tv[13] = '{1'b0, 32'h040, 32'h00000000, 3'd3, 32'h00000000, 1'b1};
    tv[14] = '{1'b1, 32'hFFC, 32'h12345678, 3'd2, 32'h00000000, 1'b0};
    tv[15] = '{1'b0, 32'hFFE, 32'h00000000, 3'd5, 32'h00001234, 1'b0};
    tv[16] = '{1'b0, 32'hFFE, 32'h00000000, 3'd1, 32'h00001234, 1'b0};
    tv[17] = '{1'b0, 32'hFFC, 32'h00000000, 3'd6, 32'h00000000, 1'b1};

    for (int i = 0; i < MEM_SIZE; i++) begin
      ram_mem[i] = 8'd0;
      ref_mem[i] = 8'd0;
    end
    rst = 1'b1; if_req = 1'b0; if_adr = 32'd0;
    dm_req = 1'b0; dm_we = 1'b0; dm_adr = 32'd0; dm_wdata = 32'd0; dm_siz = 3'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_flags", {25'd0, if_ack, if_err, dm_ack, dm_err, ram_start, ram_load, busy}, 32'd0);
    chk("rst_if_data", if_data, 32'd0);
    chk("rst_dm_rdata", dm_rdata, 32'd0);
    chk("rst_ram_adr", ram_adr, 32'd0);
    chk("rst_ram_in", ram_in, 32'd0);
    chk("rst_ram_siz", {29'd0, ram_siz}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    mon_on = 1'b1;

    // Simultaneous requests after reset: data first, then strict alternation.
    @(posedge clk); #1;
    if_adr = 32'h10; dm_we = 1'b0; dm_adr = 32'h10; dm_siz = 3'd2;
    if_req = 1'b1; dm_req = 1'b1; if_rise = $time; dm_rise = $time;
    nacks = 0; order = 4'd0;
    for (int c = 0; c < 200 && nacks < 4; c++) begin
      @(negedge clk);
      if (dm_ack || if_ack) begin
        order[3 - nacks] = dm_ack;
        nacks++;
      end
    end
    @(posedge clk); #1;
    if_req = 1'b0; dm_req = 1'b0;
    chk("arb_count", 32'(nacks), 32'd4);
    chk("arb_order", {28'd0, order}, 32'h0000000A);

    for (int i = 0; i < 18; i++) begin
      xact(1'b1, tv[i].we, tv[i].adr, tv[i].wd, tv[i].siz, rd, er, lat, nst, exp_rd, exp_er);
      chk($sformatf("vec%0d_rdata", i), rd, tv[i].exp_rd);
      chk($sformatf("vec%0d_err", i), {31'd0, er}, {31'd0, tv[i].exp_err});
      chk($sformatf("vec%0d_starts", i), 32'(nst), tv[i].exp_err ? 32'd0 : 32'd1);
      chk($sformatf("vec%0d_latency", i), 32'(lat),
          tv[i].exp_err ? 32'd2 : 32'((last_delay + 3 > 5) ? last_delay + 3 : 5));
    end

    xact(1'b0, 1'b0, 32'h10, 32'd0, 3'd2, rd, er, lat, nst, exp_rd, exp_er);
    chk("fetch_data", rd, 32'hDEADBEEF);
    chk("fetch_err", {31'd0, er}, 32'd0);
    xact(1'b0, 1'b0, 32'hFFE, 32'd0, 3'd2, rd, er, lat, nst, exp_rd, exp_er);
    chk("fetch_ffe_err", {31'd0, er}, 32'd1);
    chk("fetch_ffe_data", rd, 32'd0);
    chk("fetch_ffe_starts", 32'(nst), 32'd0);
    xact(1'b0, 1'b0, 32'hFFC, 32'd0, 3'd2, rd, er, lat, nst, exp_rd, exp_er);
    chk("fetch_ffc_data", rd, 32'h12345678);

    // RAM never answers: error after TIMEOUT wait cycles, then idle.
    hang = 1'b1;
    xact(1'b1, 1'b0, 32'h10, 32'd0, 3'd2, rd, er, lat, nst, exp_rd, exp_er);
    chk("tmo_err", {31'd0, er}, 32'd1);
    chk("tmo_rdata", rd, 32'd0);
    chk("tmo_latency", 32'(lat), 32'(TIMEOUT + 3));
    @(negedge clk);
    chk("tmo_idle", {31'd0, busy}, 32'd0);

    // Reset while waiting on the RAM abandons the access silently.
    @(posedge clk); #1;
    dm_we = 1'b0; dm_adr = 32'h20; dm_siz = 3'd0; dm_req = 1'b1; dm_rise = $time;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rstwait_busy_before", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1; dm_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rstwait_busy", {31'd0, busy}, 32'd0);
    for (int c = 0; c < 4; c++) begin
      chk("rstwait_noack", {30'd0, dm_ack, if_ack}, 32'd0);
      @(negedge clk);
    end
    hang = 1'b0;
    xact(1'b1, 1'b0, 32'h10, 32'd0, 3'd2, rd, er, lat, nst, exp_rd, exp_er);
    chk("after_rst_rdata", rd, 32'hDEADBEEF);
    chk("after_rst_err", {31'd0, er}, 32'd0);

    // Random contending traffic against the reference model.
    fork
      begin
        logic [31:0] r_rd, r_exp, a, w;
        logic r_er, r_eer, we;
        logic [2:0] s;
        int r_lat, r_nst;
        for (int k = 0; k < 60; k++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          a = rnd_adr(); w = $urandom; s = rnd_siz(); we = 1'($urandom_range(0, 1));
          xact(1'b1, we, a, w, s, r_rd, r_er, r_lat, r_nst, r_exp, r_eer);
          chk($sformatf("rnd_dm%0d_rdata", k), r_rd, r_exp);
          chk($sformatf("rnd_dm%0d_err", k), {31'd0, r_er}, {31'd0, r_eer});
        end
      end
      begin
        logic [31:0] f_rd, f_exp, a;
        logic f_er, f_eer;
        int f_lat, f_nst;
        for (int k = 0; k < 60; k++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          a = rnd_adr();
          if ($urandom_range(0, 4) != 0) a[1:0] = 2'b00;
          xact(1'b0, 1'b0, a, 32'd0, 3'd2, f_rd, f_er, f_lat, f_nst, f_exp, f_eer);
          chk($sformatf("rnd_if%0d_data", k), f_rd, f_exp);
          chk($sformatf("rnd_if%0d_err", k), {31'd0, f_er}, {31'd0, f_eer});
        end
      end
    join

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
